// File: rtl/enc_pkg.sv
// Shared definitions for the RV32I instruction encoder:
// op enum, opcode/funct constants, error codes and funct3 helper.
package enc_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_SLL  = 5'd2,
        OP_XOR  = 5'd3,
        OP_SRL  = 5'd4,
        OP_OR   = 5'd5,
        OP_AND  = 5'd6,
        OP_ADDI = 5'd7,
        OP_SLLI = 5'd8,
        OP_XORI = 5'd9,
        OP_SRLI = 5'd10,
        OP_ORI  = 5'd11,
        OP_ANDI = 5'd12,
        OP_LW   = 5'd13,
        OP_SW   = 5'd14,
        OP_BEQ  = 5'd15,
        OP_BNE  = 5'd16
    } op_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_OP    = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_ALIGN = 2'b11;

    // ALU funct3 shared by the register and immediate forms
    function automatic logic [2:0] alu_f3(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI: alu_f3 = F3_ADD;
            OP_SLL, OP_SLLI:         alu_f3 = F3_SLL;
            OP_XOR, OP_XORI:         alu_f3 = F3_XOR;
            OP_SRL, OP_SRLI:         alu_f3 = F3_SRL;
            OP_OR, OP_ORI:           alu_f3 = F3_OR;
            OP_AND, OP_ANDI:         alu_f3 = F3_AND;
            default:                 alu_f3 = F3_ADD;
        endcase
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO holding encoded instruction words.
// Push is ignored when full, pop is ignored when empty.
module enc_fifo
    import enc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage write; contents are don't-care until a push lands
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes abstract op requests into RV32I words into a FIFO.
// ENC_STATS_EN adds issued_cnt / err_cnt saturating counters.
module instr_encoder
    import enc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [12:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
`ifdef ENC_STATS_EN
    output logic [15:0]      issued_cnt,
    output logic [15:0]      err_cnt,
`endif
    output logic [CNT_W-1:0] count,
    output logic             err,
    output logic [1:0]       err_code
);

    logic [31:0] enc;
    logic [1:0]  code;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        accept;
    logic        bad;
    logic        push;
    logic        full;
    logic        empty;
    logic [31:0] head;

    assign f3     = alu_f3(in_op);
    assign f7     = (in_op == OP_SUB) ? F7_SUB : F7_BASE;
    assign accept = in_valid && in_ready;
    assign bad    = accept && (code != ERR_NONE);
    assign push   = accept && (code == ERR_NONE);

    // Encode and validate the current request
    always_comb begin
        enc  = '0;
        code = ERR_NONE;
        case (in_op)
            OP_ADD, OP_SUB, OP_SLL, OP_XOR,
            OP_SRL, OP_OR, OP_AND: begin
                enc = {f7, in_rs2, in_rs1, f3, in_rd, OPC_R};
            end
            OP_ADDI, OP_XORI, OP_ORI, OP_ANDI: begin
                enc = {in_imm[11:0], in_rs1, f3, in_rd, OPC_I};
                if (in_imm[12] != in_imm[11]) code = ERR_RANGE;
            end
            OP_SLLI, OP_SRLI: begin
                enc = {7'b0, in_imm[4:0], in_rs1, f3, in_rd, OPC_I};
                if (in_imm[12:5] != '0) code = ERR_RANGE;
            end
            OP_LW: begin
                enc = {in_imm[11:0], in_rs1, F3_W, in_rd, OPC_LOAD};
                if (in_imm[12] != in_imm[11]) code = ERR_RANGE;
            end
            OP_SW: begin
                enc = {in_imm[11:5], in_rs2, in_rs1, F3_W,
                       in_imm[4:0], OPC_STORE};
                if (in_imm[12] != in_imm[11]) code = ERR_RANGE;
            end
            OP_BEQ, OP_BNE: begin
                enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                       (in_op == OP_BNE) ? F3_BNE : F3_BEQ,
                       in_imm[4:1], in_imm[11], OPC_BRANCH};
                if (in_imm[0]) code = ERR_ALIGN;
            end
            default: begin
                code = ERR_OP;
            end
        endcase
    end

    enc_fifo #(
        .DEPTH (DEPTH),
        .W     (32),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (enc),
        .pop   (out_ready),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_instr = empty ? 32'h0 : head;

    // Error pulse for rejected requests; code sticks until the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            err <= bad;
            if (bad) begin
                err_code <= code;
            end
        end
    end

`ifdef ENC_STATS_EN
    // Saturating counters of pushed and rejected requests
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt <= '0;
            err_cnt    <= '0;
        end else begin
            if (push && issued_cnt != 16'hFFFF) begin
                issued_cnt <= issued_cnt + 1'b1;
            end
            if (bad && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
